control_unit_gen: RTL
=====================

CONTROL_UNIT_GEN -- requirements
Module: control_unit_gen

Interface
REQ-001 Parameter WORD_SIZE, default 8: instruction width; SHALL equal OP_SIZE + 2*REG_AW.
REQ-002 Parameter OP_SIZE, default 4: opcode field width.
REQ-003 Parameter REG_CNT, default 4: general registers, power of 2 (2..16); REG_AW = log2(REG_CNT).
REQ-004 Parameter MUL_TIMEOUT, default 32: maximum cycles to wait for mul_done (1..255).
REQ-005 clk  in  1  single clock, all state updates on rising edge.
REQ-006 rst  in  1  reset is synchronous and active-low.
REQ-007 instruction  in  WORD_SIZE  IR contents: opcode [MSBs], src [2*REG_AW-1:REG_AW], dest [REG_AW-1:0].
REQ-008 zero, over_flow, mul_done  in  1 each  ALU zero flag, overflow flag, multiplier completion.
REQ-009 Load_R  out  REG_CNT  one-hot register load strobes.
REQ-010 Sel_Bus_1_Mux  out  REG_AW+1  value 0..REG_CNT-1 selects a register; value REG_CNT selects PC.
REQ-011 Sel_Bus_2_Mux  out  3  0 ALU, 1 Bus_1, 2 Mem, 3 mul LSB, 4 mul MSB.
REQ-012 Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Load_Reg_ov, Load_Reg_md, write  out  1 each  datapath strobes.
REQ-013 halted  out  1  high while in S_halt; err_code  out  2  0 none, 1 illegal opcode, 2 multiply timeout.

Function
REQ-014 Outputs SHALL be combinational from state, opcode, src, dest, zero, over_flow, mul_done; unselected mux outputs SHALL be 0, and all strobes SHALL be 0 unless they are listed for the current state.
REQ-015 States: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_mul, S_mwait, S_mmsb, S_halt; encoding is free.
REQ-016 S_idle->S_fet1. S_fet1: Sel_Bus_1=PC, Sel_Bus_2=1, Load_Add_R; ->S_fet2. S_fet2: Sel_Bus_2=2, Load_IR, Inc_PC; ->S_dec.
REQ-017 S_dec opcodes: NOP 0 -> S_fet1. ADD/SUB/AND 1/2/3: Sel_Bus_1=src, Sel_Bus_2=1, Load_Reg_Y; ->S_ex1.
REQ-018 NOT 4: Sel_Bus_1=src, Sel_Bus_2=0, Load_Reg_Z, Load_R[dest]; ->S_fet1.
REQ-019 RD 5 / WR 6 / BR 7: Sel_Bus_1=PC, Sel_Bus_2=1, Load_Add_R; go to S_rd1 / S_wr1 / S_br1 respectively.
REQ-020 BRZ 8 / BRO 9: if zero / over_flow is 1, act as BR; otherwise Inc_PC and ->S_fet1.
REQ-021 MUL 10: Sel_Bus_1=src, Sel_Bus_2=1, Load_Reg_Y; ->S_mul.
REQ-022 Opcodes 11-14 -> S_halt with err_code=1. Opcode 15 (HALT) -> S_halt with err_code=0.
REQ-023 S_ex1: Sel_Bus_1=dest, Sel_Bus_2=0, Load_Reg_Z, Load_Reg_ov, Load_R[dest]; ->S_fet1.
REQ-024 S_rd1 and S_wr1: Sel_Bus_2=2, Load_Add_R, Inc_PC; go to S_rd2 / S_wr2 respectively. S_rd2: Sel_Bus_2=2, Load_R[dest]; ->S_fet1. S_wr2: Sel_Bus_1=src, write; ->S_fet1.
REQ-025 S_br1: Sel_Bus_2=2, Load_Add_R; ->S_br2. S_br2: Sel_Bus_2=2, Load_PC; ->S_fet1.
REQ-026 S_mul: Sel_Bus_1=dest, Load_Reg_md for exactly 1 cycle; clear the wait counter; ->S_mwait.
REQ-027 S_mwait with mul_done=0: Sel_Bus_1=dest and no strobes; increment the 8-bit wait counter, saturating at 255.
REQ-028 S_mwait with mul_done=1: Sel_Bus_2=3, Load_R[src], Load_Reg_Z, Load_Reg_ov; ->S_mmsb. mul_done has priority over timeout in the same cycle.
REQ-029 S_mwait with counter == MUL_TIMEOUT-1 and mul_done=0: ->S_halt with err_code=2.
REQ-030 S_mmsb: Sel_Bus_2=4, Load_R[dest], Load_Reg_Z, Load_Reg_ov; ->S_fet1. When src == dest, the MSB write wins.
REQ-031 S_halt SHALL be absorbing until reset; err_code is registered and held; halted=1. An illegal state encoding ->S_idle.

Reset
REQ-032 With rst=0 at a rising clk edge: state<=S_idle, wait counter<=0, err_code<=0, from any state including S_mwait and S_halt.
REQ-033 During and directly after reset, every output SHALL be 0.

Configuration
REQ-034 Macro CU_MUL_EN defined: MUL, S_mul, S_mwait, S_mmsb and the wait counter exist as specified.
REQ-035 Macro CU_MUL_EN undefined: opcode 10 is illegal (S_halt, err_code=1), Load_Reg_md is tied to 0, Sel_Bus_2_Mux never takes 3 or 4, and no counter is synthesised.

Verification
REQ-036 Reset then ADD R1,R2 (0x19), zero=0 -> fetch 2 cycles, dec: Sel_Bus_1=2, Load_Reg_Y; ex1: Load_R=4'b0010, Sel_Bus_2=0; back to S_fet1.
REQ-037 BRZ (0x80) with zero=0 -> S_dec asserts Inc_PC then S_fet1; with zero=1 -> sequence br1, br2 with Load_PC in br2.
REQ-038 MUL R3,R0 (0xAC), mul_done after 5 cycles -> Load_Reg_md 1 cycle; LSB: Load_R=4'b1000, Sel_Bus_2=3; MSB: Load_R=4'b0001, Sel_Bus_2=4.
REQ-039 MUL with mul_done held 0, MUL_TIMEOUT=4 -> S_halt 4 cycles after S_mwait entry, halted=1, err_code=2; rst=0 for 1 cycle -> all outputs 0 in S_idle.
REQ-040 Opcode 0xC0 -> halted=1, err_code=1, stays halted for 20 cycles; rebuild without CU_MUL_EN and apply 0xA0 -> err_code=1.
REQ-041 REG_CNT=8, WORD_SIZE=10, NOT R5,R6 (0x12E) -> Sel_Bus_1=5, Load_R=8'b01000000; PC fetch drives Sel_Bus_1=8.

Source files
------------

// File: rtl/control_unit_gen.sv
// control_unit_gen: multi-cycle instruction sequencer producing register-file, bus-mux and
// memory strobes. Defining CU_MUL_EN adds multiplier sequencing with a completion timeout.
module control_unit_gen #(
  parameter int  WORD_SIZE   = 8,
  parameter int  OP_SIZE     = 4,
  parameter int  REG_CNT     = 4,
  parameter int  MUL_TIMEOUT = 32,
  localparam int REG_AW      = $clog2(REG_CNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instruction,
  input  logic                 zero,
  input  logic                 over_flow,
  input  logic                 mul_done,
  output logic [REG_CNT-1:0]   Load_R,
  output logic [REG_AW:0]      Sel_Bus_1_Mux,
  output logic [2:0]           Sel_Bus_2_Mux,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Y,
  output logic                 Load_Reg_Z,
  output logic                 Load_Reg_ov,
  output logic                 Load_Reg_md,
  output logic                 write,
  output logic                 halted,
  output logic [1:0]           err_code
);

  typedef enum logic [3:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2,
    S_br1, S_br2, S_mul, S_mwait, S_mmsb, S_halt
  } state_t;

  localparam logic [OP_SIZE-1:0] OP_NOP  = OP_SIZE'(4'd0);
  localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'd1);
  localparam logic [OP_SIZE-1:0] OP_SUB  = OP_SIZE'(4'd2);
  localparam logic [OP_SIZE-1:0] OP_AND  = OP_SIZE'(4'd3);
  localparam logic [OP_SIZE-1:0] OP_NOT  = OP_SIZE'(4'd4);
  localparam logic [OP_SIZE-1:0] OP_RD   = OP_SIZE'(4'd5);
  localparam logic [OP_SIZE-1:0] OP_WR   = OP_SIZE'(4'd6);
  localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(4'd7);
  localparam logic [OP_SIZE-1:0] OP_BRZ  = OP_SIZE'(4'd8);
  localparam logic [OP_SIZE-1:0] OP_BRO  = OP_SIZE'(4'd9);
  localparam logic [OP_SIZE-1:0] OP_MUL  = OP_SIZE'(4'd10);
  localparam logic [OP_SIZE-1:0] OP_HALT = OP_SIZE'(4'd15);
  localparam logic [REG_AW:0]    SEL1_PC = (REG_AW+1)'(REG_CNT);

  state_t             state_r;
  logic [1:0]         err_code_r;
  logic [OP_SIZE-1:0] opcode_s;
  logic [REG_AW-1:0]  src_s;
  logic [REG_AW-1:0]  dest_s;
  logic [REG_CNT-1:0] src_oh_s;
  logic [REG_CNT-1:0] dest_oh_s;
  logic [REG_AW:0]    src_sel_s;
  logic [REG_AW:0]    dest_sel_s;
  logic               br_taken_s;

  assign opcode_s   = instruction[WORD_SIZE-1 -: OP_SIZE];
  assign src_s      = instruction[2*REG_AW-1:REG_AW];
  assign dest_s     = instruction[REG_AW-1:0];
  assign src_oh_s   = REG_CNT'(1'b1) << src_s;
  assign dest_oh_s  = REG_CNT'(1'b1) << dest_s;
  assign src_sel_s  = {1'b0, src_s};
  assign dest_sel_s = {1'b0, dest_s};
  // BR is unconditional; BRZ/BRO fall through to the next fetch when their flag is clear
  assign br_taken_s = (opcode_s == OP_BR) || ((opcode_s == OP_BRZ) && zero) ||
                      ((opcode_s == OP_BRO) && over_flow);

`ifdef CU_MUL_EN
  localparam logic [7:0] WAIT_LAST = 8'(MUL_TIMEOUT - 1);
  logic [7:0] wait_cnt_r;
`else
  logic unused_s;
  assign unused_s = mul_done ^ (MUL_TIMEOUT == 32'sd0);
`endif

  // State sequencing, multiplier wait counter and latched error code
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_idle;
      err_code_r <= 2'd0;
`ifdef CU_MUL_EN
      wait_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_idle: state_r <= S_fet1;
        S_fet1: state_r <= S_fet2;
        S_fet2: state_r <= S_dec;
        S_dec: begin
          case (opcode_s)
            OP_NOP, OP_NOT:         state_r <= S_fet1;
            OP_ADD, OP_SUB, OP_AND: state_r <= S_ex1;
            OP_RD:                  state_r <= S_rd1;
            OP_WR:                  state_r <= S_wr1;
            OP_BR, OP_BRZ, OP_BRO:  state_r <= br_taken_s ? S_br1 : S_fet1;
`ifdef CU_MUL_EN
            OP_MUL:                 state_r <= S_mul;
`endif
            OP_HALT: begin
              state_r    <= S_halt;
              err_code_r <= 2'd0;
            end
            default: begin
              state_r    <= S_halt;
              err_code_r <= 2'd1;
            end
          endcase
        end
        S_ex1, S_rd2, S_wr2, S_br2: state_r <= S_fet1;
        S_rd1: state_r <= S_rd2;
        S_wr1: state_r <= S_wr2;
        S_br1: state_r <= S_br2;
`ifdef CU_MUL_EN
        S_mul: begin
          state_r    <= S_mwait;
          wait_cnt_r <= 8'd0;
        end
        S_mwait: begin
          // a completion arriving on the last allowed cycle still wins over the timeout
          if (mul_done) begin
            state_r <= S_mmsb;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= S_halt;
            err_code_r <= 2'd2;
          end
          if (!mul_done && (wait_cnt_r != 8'hFF)) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_mmsb: state_r <= S_fet1;
`endif
        S_halt:  state_r <= S_halt;
        default: state_r <= S_idle;
      endcase
    end
  end

  // Datapath strobes and mux selects decoded from state and the current instruction
  always_comb begin
    Load_R        = {REG_CNT{1'b0}};
    Sel_Bus_1_Mux = {(REG_AW+1){1'b0}};
    Sel_Bus_2_Mux = 3'd0;
    Load_PC       = 1'b0;
    Inc_PC        = 1'b0;
    Load_IR       = 1'b0;
    Load_Add_R    = 1'b0;
    Load_Reg_Y    = 1'b0;
    Load_Reg_Z    = 1'b0;
    Load_Reg_ov   = 1'b0;
    Load_Reg_md   = 1'b0;
    write         = 1'b0;
    halted        = 1'b0;
    err_code      = 2'd0;
    if (rst) begin
      err_code = err_code_r;
      case (state_r)
        S_fet1: begin
          Sel_Bus_1_Mux = SEL1_PC;
          Sel_Bus_2_Mux = 3'd1;
          Load_Add_R    = 1'b1;
        end
        S_fet2: begin
          Sel_Bus_2_Mux = 3'd2;
          Load_IR       = 1'b1;
          Inc_PC        = 1'b1;
        end
        S_dec: begin
          case (opcode_s)
            OP_ADD, OP_SUB, OP_AND
`ifdef CU_MUL_EN
            , OP_MUL
`endif
            : begin
              Sel_Bus_1_Mux = src_sel_s;
              Sel_Bus_2_Mux = 3'd1;
              Load_Reg_Y    = 1'b1;
            end
            OP_NOT: begin
              Sel_Bus_1_Mux = src_sel_s;
              Load_Reg_Z    = 1'b1;
              Load_R        = dest_oh_s;
            end
            OP_RD, OP_WR, OP_BR, OP_BRZ, OP_BRO: begin
              if (br_taken_s || (opcode_s == OP_RD) || (opcode_s == OP_WR)) begin
                Sel_Bus_1_Mux = SEL1_PC;
                Sel_Bus_2_Mux = 3'd1;
                Load_Add_R    = 1'b1;
              end else begin
                Inc_PC = 1'b1;
              end
            end
            default: Load_R = {REG_CNT{1'b0}};
          endcase
        end
        S_ex1: begin
          Sel_Bus_1_Mux = dest_sel_s;
          Load_Reg_Z    = 1'b1;
          Load_Reg_ov   = 1'b1;
          Load_R        = dest_oh_s;
        end
        S_rd1, S_wr1: begin
          Sel_Bus_2_Mux = 3'd2;
          Load_Add_R    = 1'b1;
          Inc_PC        = 1'b1;
        end
        S_rd2: begin
          Sel_Bus_2_Mux = 3'd2;
          Load_R        = dest_oh_s;
        end
        S_wr2: begin
          Sel_Bus_1_Mux = src_sel_s;
          write         = 1'b1;
        end
        S_br1: begin
          Sel_Bus_2_Mux = 3'd2;
          Load_Add_R    = 1'b1;
        end
        S_br2: begin
          Sel_Bus_2_Mux = 3'd2;
          Load_PC       = 1'b1;
        end
`ifdef CU_MUL_EN
        S_mul: begin
          Sel_Bus_1_Mux = dest_sel_s;
          Load_Reg_md   = 1'b1;
        end
        S_mwait: begin
          if (mul_done) begin
            Sel_Bus_2_Mux = 3'd3;
            Load_R        = src_oh_s;
            Load_Reg_Z    = 1'b1;
            Load_Reg_ov   = 1'b1;
          end else begin
            Sel_Bus_1_Mux = dest_sel_s;
          end
        end
        S_mmsb: begin
          Sel_Bus_2_Mux = 3'd4;
          Load_R        = dest_oh_s;
          Load_Reg_Z    = 1'b1;
          Load_Reg_ov   = 1'b1;
        end
`endif
        S_halt:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end else begin
      err_code = 2'd0;
    end
  end

endmodule
